// File: rtl/cpu_mem_bridge_if.sv
// CPU / BRAM / status bundle for cpu_mem_bridge; the I/O side exists only when
// CPU_MEM_BRIDGE_IO_EN is defined. "slave" is the bridge, "master" its environment.
interface cpu_mem_bridge_if #(
    parameter int CPU_DW = 4,
    parameter int CPU_AW = 12,
    parameter int SYS_DW = 32,
    parameter int SYS_AW = 32
);
    logic                  cpu_re;
    logic                  cpu_we;
    logic [CPU_AW-1:0]     cpu_addr;
    logic [CPU_DW-1:0]     cpu_wdata;
    logic [CPU_DW-1:0]     cpu_rdata;
    logic                  cpu_stop;
    logic                  bram_en;
    logic [SYS_DW/8-1:0]   bram_we;
    logic [SYS_AW-1:0]     bram_addr;
    logic [SYS_DW-1:0]     bram_wdata;
    logic [SYS_DW-1:0]     bram_rdata;
    logic                  bus_err;
    logic                  err_clr;
`ifdef CPU_MEM_BRIDGE_IO_EN
    logic                  io_req;
    logic                  io_we;
    logic [7:0]            io_addr;
    logic [CPU_DW-1:0]     io_wdata;
    logic [CPU_DW-1:0]     io_rdata;
    logic                  io_ack;
`endif

    modport slave (
        input  cpu_re, cpu_we, cpu_addr, cpu_wdata, bram_rdata, err_clr,
        output cpu_rdata, cpu_stop, bram_en, bram_we, bram_addr, bram_wdata, bus_err
`ifdef CPU_MEM_BRIDGE_IO_EN
        , output io_req, io_we, io_addr, io_wdata
        , input  io_rdata, io_ack
`endif
    );

    modport master (
        output cpu_re, cpu_we, cpu_addr, cpu_wdata, bram_rdata, err_clr,
        input  cpu_rdata, cpu_stop, bram_en, bram_we, bram_addr, bram_wdata, bus_err
`ifdef CPU_MEM_BRIDGE_IO_EN
        , input  io_req, io_we, io_addr, io_wdata
        , output io_rdata, io_ack
`endif
    );
endinterface

// File: rtl/cpu_mem_bridge.sv
// Narrow CPU bus to wide BRAM bridge with a stalling read path and an optional
// acknowledged I/O region (enabled by defining CPU_MEM_BRIDGE_IO_EN).
module cpu_mem_bridge #(
    parameter int                CPU_DW  = 4,
    parameter int                CPU_AW  = 12,
    parameter int                SYS_DW  = 32,
    parameter int                SYS_AW  = 32,
    parameter int                RD_LAT  = 1,
    parameter logic [CPU_AW-1:0] IO_BASE = 12'hF00,
    parameter int                IO_TMO  = 15
) (
    input logic              clk,
    input logic              reset,
    cpu_mem_bridge_if.slave  bus
);
    localparam int BE_W    = SYS_DW / 8;
    localparam int CNT_MAX = (IO_TMO > RD_LAT) ? IO_TMO : RD_LAT;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    typedef enum logic [1:0] {IDLE, BRD, IOW, DONE} state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic             io_sel;
    logic             wr;
    logic             rd;
    logic             tmo;
    logic             err_set;
    logic             unused_rdata;

    // Requests are only looked at in IDLE; a simultaneous re/we counts as a write.
    assign io_sel = bus.cpu_addr >= IO_BASE;
    assign wr     = (state == IDLE) && bus.cpu_we;
    assign rd     = (state == IDLE) && bus.cpu_re && !bus.cpu_we;
    assign unused_rdata = ^bus.bram_rdata;

`ifdef CPU_MEM_BRIDGE_IO_EN
    assign tmo     = (state == IOW) && !bus.io_ack && (cnt == CNT_W'(1));
    assign err_set = ((state == IDLE) && bus.cpu_re && bus.cpu_we) || tmo;
`else
    assign tmo     = 1'b0;
    assign err_set = ((state == IDLE) && bus.cpu_re && bus.cpu_we) || ((wr || rd) && io_sel);
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if ((wr || rd) && io_sel) begin
`ifdef CPU_MEM_BRIDGE_IO_EN
                    state_nxt = IOW;
`else
                    if (rd) state_nxt = DONE;
`endif
                end else if (rd) begin
                    state_nxt = BRD;
                end
            end
            BRD:  if (cnt == CNT_W'(1)) state_nxt = DONE;
`ifdef CPU_MEM_BRIDGE_IO_EN
            IOW:  if (bus.io_ack || tmo) state_nxt = DONE;
`else
            IOW:  state_nxt = IDLE;
`endif
            default: state_nxt = IDLE;
        endcase
    end

    // BRAM strobes exist only in the IDLE issue cycle; everything else stays zero.
    always_comb begin
        bus.bram_en    = 1'b0;
        bus.bram_we    = '0;
        bus.bram_addr  = '0;
        bus.bram_wdata = '0;
        bus.cpu_stop   = 1'b0;
        case (state)
            IDLE: begin
                if ((wr || rd) && !io_sel) begin
                    bus.bram_en   = 1'b1;
                    bus.bram_addr = SYS_AW'(bus.cpu_addr);
                    if (wr) begin
                        bus.bram_we    = BE_W'(1);
                        bus.bram_wdata = SYS_DW'(bus.cpu_wdata);
                    end
                end
`ifdef CPU_MEM_BRIDGE_IO_EN
                bus.cpu_stop = rd || (wr && io_sel);
`else
                bus.cpu_stop = rd;
`endif
            end
            BRD, IOW: bus.cpu_stop = 1'b1;
            default:  bus.cpu_stop = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt           <= '0;
            bus.cpu_rdata <= '0;
`ifdef CPU_MEM_BRIDGE_IO_EN
            bus.io_req    <= 1'b0;
            bus.io_we     <= 1'b0;
            bus.io_addr   <= '0;
            bus.io_wdata  <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (rd && !io_sel) begin
                        cnt <= CNT_W'(RD_LAT);
                    end else if ((wr || rd) && io_sel) begin
`ifdef CPU_MEM_BRIDGE_IO_EN
                        cnt          <= CNT_W'(IO_TMO);
                        bus.io_req   <= 1'b1;
                        bus.io_we    <= wr;
                        bus.io_addr  <= bus.cpu_addr[7:0];
                        bus.io_wdata <= bus.cpu_wdata;
`else
                        if (rd) bus.cpu_rdata <= '0;
`endif
                    end
                end
                BRD: begin
                    cnt <= cnt - 1'b1;
                    if (cnt == CNT_W'(1)) bus.cpu_rdata <= bus.bram_rdata[CPU_DW-1:0];
                end
`ifdef CPU_MEM_BRIDGE_IO_EN
                IOW: begin
                    cnt <= cnt - 1'b1;
                    if (bus.io_ack) begin
                        cnt        <= '0;
                        bus.io_req <= 1'b0;
                        if (!bus.io_we) bus.cpu_rdata <= bus.io_rdata;
                    end else if (tmo) begin
                        bus.io_req <= 1'b0;
                        if (!bus.io_we) bus.cpu_rdata <= '1;
                    end
                end
`endif
                default: ;
            endcase
        end
    end

    // A new error event wins over a clear in the same cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)            bus.bus_err <= 1'b0;
        else if (err_set)     bus.bus_err <= 1'b1;
        else if (bus.err_clr) bus.bus_err <= 1'b0;
    end
endmodule
